aes_kat_sequencer: RTL and testbench

- Known-answer-test controller for the AES-128 core in the hardware verification platform.
- While `work` is high, it fetches {key, plaintext, expected ciphertext} vectors from a synchronous vector ROM and issues each one to the AES core with a start/done handshake.
- It compares each core result against the expected ciphertext and accumulates `total` and `correct` counters for the platform top.

---
 rtl/aes_kat_if.sv | 31 +++
 rtl/aes_kat_sequencer.sv | 145 ++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_kat_if.sv
// aes_kat_if: groups the vector-ROM read port and the AES core start/done
// handshake used by the known-answer-test sequencer.
//   rom_addr            sequencer -> ROM, data valid one cycle later
//   rom_key/pt/ct       ROM -> sequencer, vector fields
//   aes_start           sequencer -> core, one-cycle start pulse
//   aes_key/aes_din     sequencer -> core, held from start until next load
//   aes_done/aes_dout   core -> sequencer, one-cycle done with result
// master = sequencer side, slave = ROM/core side.
interface aes_kat_if #(
  parameter int AW = 4
);
  logic [AW-1:0] rom_addr;
  logic [127:0]  rom_key;
  logic [127:0]  rom_pt;
  logic [127:0]  rom_ct;
  logic          aes_start;
  logic [127:0]  aes_key;
  logic [127:0]  aes_din;
  logic          aes_done;
  logic [127:0]  aes_dout;

  modport master (
    output rom_addr, aes_start, aes_key, aes_din,
    input  rom_key, rom_pt, rom_ct, aes_done, aes_dout
  );

  modport slave (
    input  rom_addr, aes_start, aes_key, aes_din,
    output rom_key, rom_pt, rom_ct, aes_done, aes_dout
  );
endinterface

// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: known-answer-test controller for the AES-128 core.
// While work is high it reads {key, plaintext, expected ct} vectors from a
// synchronous ROM, runs each through the core with a start/done handshake,
// and keeps saturating total/correct counters.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   work          level enable, sampled in IDLE, NEXT and DONE only
//   bus           aes_kat_if master: ROM read port + AES core handshake
//   total         vectors completed (pass, fail or timeout), saturating
//   correct       vectors whose core result matched, saturating
//   run_done      high while parked in DONE (LOOP=0 only)
//   timeout_err   sticky, set when any vector times out
module aes_kat_sequencer #(
  parameter int NUM_VEC = 16,
  parameter int AW      = 4,
  parameter int CW      = 16,
  parameter int TIMEOUT = 63,
  parameter int LOOP    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          work,
  aes_kat_if.master     bus,
  output logic [CW-1:0] total,
  output logic [CW-1:0] correct,
  output logic          run_done,
  output logic          timeout_err
);

  localparam int             TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]  LAST = AW'(NUM_VEC - 1);
  localparam logic [TW-1:0]  TMO  = TW'(TIMEOUT);
  localparam logic [CW-1:0]  CMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  state_t        nstate;
  logic [127:0]  exp_ct;
  logic [TW-1:0] tmo_cnt;
  logic          pass;

  logic start_d;
  logic run_done_d;
  logic ld_vec;
  logic wait_st;
  logic done_hit;
  logic tmo_hit;
  logic bump;
  logic adv;
  logic last_vec;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  assign last_vec = (bus.rom_addr == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (work) nstate = S_FETCH;
      S_FETCH: nstate = S_LOAD;
      S_LOAD:  nstate = S_START;
      S_START: nstate = S_WAIT;
      // done has priority over a simultaneous timeout; both leave WAIT
      S_WAIT:  if (bus.aes_done || (tmo_cnt == TMO)) nstate = S_CHECK;
      S_CHECK: nstate = S_NEXT;
      S_NEXT: begin
        if (last_vec && (LOOP == 0)) nstate = S_DONE;
        else if (!work)              nstate = S_IDLE;
        else                         nstate = S_FETCH;
      end
      S_DONE:  if (!work) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so that aes_start and
  // run_done are high exactly while the FSM sits in START / DONE.
  always_comb begin
    start_d    = (nstate == S_START);
    run_done_d = (nstate == S_DONE);
    ld_vec     = (state == S_LOAD);
    wait_st    = (state == S_WAIT);
    done_hit   = wait_st && bus.aes_done;
    tmo_hit    = wait_st && !bus.aes_done && (tmo_cnt == TMO);
    bump       = (state == S_CHECK);
    adv        = (state == S_NEXT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rom_addr  <= '0;
      bus.aes_start <= 1'b0;
      bus.aes_key   <= '0;
      bus.aes_din   <= '0;
      exp_ct        <= '0;
      tmo_cnt       <= '0;
      pass          <= 1'b0;
      total         <= '0;
      correct       <= '0;
      run_done      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      bus.aes_start <= start_d;
      run_done      <= run_done_d;

      if (ld_vec) begin
        bus.aes_key <= bus.rom_key;
        bus.aes_din <= bus.rom_pt;
        exp_ct      <= bus.rom_ct;
      end

      if (state == S_START)
        tmo_cnt <= '0;
      else if (wait_st && (tmo_cnt != TMO))
        tmo_cnt <= tmo_cnt + TW'(1);

      if (done_hit) begin
        pass <= (bus.aes_dout == exp_ct);
      end else if (tmo_hit) begin
        pass        <= 1'b0;
        timeout_err <= 1'b1;
      end

      if (bump) begin
        total <= sat_inc(total);
        if (pass) correct <= sat_inc(correct);
      end

      if (adv)
        bus.rom_addr <= last_vec ? '0 : bus.rom_addr + AW'(1);
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Bench for aes_kat_sequencer: two instances (LOOP=0/CW=16 and LOOP=1/CW=3),
// a synchronous ROM model, a fixed-latency core model and a scoreboard of
// expected vectors and counter outcomes.
module tb_aes_kat_sequencer;
  localparam int NV = 4;
  localparam int AW = 2;
  localparam int L1 = 11;
  localparam int L2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic work1 = 1'b0;
  logic work2 = 1'b0;

  logic [15:0] total1, correct1;
  logic        run_done1, tmo1;
  logic [2:0]  total2, correct2;
  logic        run_done2, tmo2;

  aes_kat_if #(.AW(AW)) if1 ();
  aes_kat_if #(.AW(AW)) if2 ();

  aes_kat_sequencer #(.NUM_VEC(NV), .AW(AW), .CW(16), .TIMEOUT(63), .LOOP(0)) u1 (
    .clk(clk), .rst(rst), .work(work1), .bus(if1.master),
    .total(total1), .correct(correct1), .run_done(run_done1), .timeout_err(tmo1)
  );

  aes_kat_sequencer #(.NUM_VEC(NV), .AW(AW), .CW(3), .TIMEOUT(63), .LOOP(1)) u2 (
    .clk(clk), .rst(rst), .work(work2), .bus(if2.master),
    .total(total2), .correct(correct2), .run_done(run_done2), .timeout_err(tmo2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [127:0] rk [NV];
  logic [127:0] rp [NV];
  logic [127:0] rc [NV];

  int          idx_q1[$];
  int          idx_q2[$];
  logic [31:0] out_q1[$];
  logic [5:0]  out_q2[$];
  int          sc1[$];
  int          starts1 = 0;
  int          starts2 = 0;
  logic [15:0] prev_t1 = '0;
  logic [2:0]  prev_t2 = '0;

  int sup1 = -1;
  bit late_en = 1'b0;
  int pend1 = -1;
  int late1 = -1;
  int pend2 = -1;
  logic [127:0] k1, d1, k2, d2;

  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] p);
    return k ^ {p[63:0], p[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous ROM: address sampled at the edge, data presented just after.
  initial begin : rom_model
    int a1, a2;
    forever begin
      @(posedge clk);
      a1 = int'(if1.rom_addr);
      a2 = int'(if2.rom_addr);
      #1;
      if1.rom_key = rk[a1]; if1.rom_pt = rp[a1]; if1.rom_ct = rc[a1];
      if2.rom_key = rk[a2]; if2.rom_pt = rp[a2]; if2.rom_ct = rc[a2];
    end
  end

  // Core model: done is high L cycles after the cycle in which start was high.
  initial begin : core_model
    if1.aes_done = 1'b0; if1.aes_dout = '0;
    if2.aes_done = 1'b0; if2.aes_dout = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend1 = -1; late1 = -1; pend2 = -1;
        if1.aes_done = 1'b0; if2.aes_done = 1'b0;
      end else begin
        if1.aes_done = 1'b0;
        if2.aes_done = 1'b0;
        if (cyc == pend1 || cyc == late1) begin
          if1.aes_done = 1'b1;
          if1.aes_dout = core_f(k1, d1);
          if (cyc == pend1) pend1 = -1;
          if (cyc == late1) late1 = -1;
        end
        if (cyc == pend2) begin
          if2.aes_done = 1'b1;
          if2.aes_dout = core_f(k2, d2);
          pend2 = -1;
        end
        if (if1.aes_start) begin
          k1 = if1.aes_key; d1 = if1.aes_din;
          if (sup1 >= 0 && if1.aes_key == rk[sup1]) begin
            if (late_en) late1 = cyc + 69;
          end else begin
            pend1 = cyc + L1;
          end
        end
        if (if2.aes_start) begin
          k2 = if2.aes_key; d2 = if2.aes_din;
          pend2 = cyc + L2;
        end
      end
    end
  end

  // Scoreboard monitors: vectors issued and counter outcomes.
  initial begin : mon
    int e;
    logic [31:0] o1;
    logic [5:0]  o2;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if1.aes_start) begin
          starts1++;
          sc1.push_back(cyc);
          checks++;
          if (idx_q1.size() == 0) begin
            errors++;
            $display("FAIL start1_unexpected: start seen with key=%h, required no start", if1.aes_key);
          end else begin
            e = idx_q1.pop_front();
            if (if1.aes_key !== rk[e] || if1.aes_din !== rp[e]) begin
              errors++;
              $display("FAIL start1_vector: key=%h din=%h, required key=%h din=%h", if1.aes_key, if1.aes_din, rk[e], rp[e]);
            end
          end
        end
        if (total1 !== prev_t1) begin
          prev_t1 = total1;
          checks++;
          if (out_q1.size() == 0) begin
            errors++;
            $display("FAIL count1_unexpected: total=%0d correct=%0d, required no change", total1, correct1);
          end else begin
            o1 = out_q1.pop_front();
            if ({total1, correct1} !== o1) begin
              errors++;
              $display("FAIL count1: total=%0d correct=%0d, required total=%0d correct=%0d", total1, correct1, o1[31:16], o1[15:0]);
            end
          end
        end
        if (if2.aes_start) begin
          starts2++;
          checks++;
          if (idx_q2.size() == 0) begin
            errors++;
            $display("FAIL start2_unexpected: start seen with key=%h, required no start", if2.aes_key);
          end else begin
            e = idx_q2.pop_front();
            if (if2.aes_key !== rk[e] || if2.aes_din !== rp[e]) begin
              errors++;
              $display("FAIL start2_vector: key=%h, required key=%h (vec %0d)", if2.aes_key, rk[e], e);
            end
          end
        end
        if (total2 !== prev_t2) begin
          prev_t2 = total2;
          checks++;
          if (out_q2.size() == 0) begin
            errors++;
            $display("FAIL count2_unexpected: total=%0d correct=%0d, required no change", total2, correct2);
          end else begin
            o2 = out_q2.pop_front();
            if ({total2, correct2} !== o2) begin
              errors++;
              $display("FAIL count2: total=%0d correct=%0d, required total=%0d correct=%0d", total2, correct2, o2[5:3], o2[2:0]);
            end
          end
        end
      end
    end
  end

  task automatic clear_sb();
    idx_q1.delete(); idx_q2.delete(); out_q1.delete(); out_q2.delete(); sc1.delete();
    starts1 = 0; starts2 = 0; prev_t1 = '0; prev_t2 = '0;
    sup1 = -1; late_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; work1 = 1'b0; work2 = 1'b0;
    clear_sb();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_starts1(input int n, input int budget);
    for (int i = 0; i < budget && starts1 < n; i++) @(negedge clk);
    if (starts1 < n) begin
      checks++; errors++;
      $display("FAIL wait_starts1: starts=%0d, required %0d", starts1, n);
    end
  endtask

  task automatic wait_starts2(input int n, input int budget);
    for (int i = 0; i < budget && starts2 < n; i++) @(negedge clk);
    if (starts2 < n) begin
      checks++; errors++;
      $display("FAIL wait_starts2: starts=%0d, required %0d", starts2, n);
    end
  endtask

  task automatic wait_total1(input int n, input int budget);
    for (int i = 0; i < budget && int'(total1) != n; i++) @(negedge clk);
    if (int'(total1) != n) begin
      checks++; errors++;
      $display("FAIL wait_total1: total=%0d, required %0d", total1, n);
    end
  endtask

  task automatic wait_run_done1(input int budget);
    for (int i = 0; i < budget && run_done1 !== 1'b1; i++) @(negedge clk);
    if (run_done1 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_run_done1: run_done=%b, required 1", run_done1);
    end
  endtask

  task automatic push_run1(input int c0, input int c1, input int c2, input int c3);
    for (int i = 0; i < NV; i++) idx_q1.push_back(i);
    out_q1.push_back({16'd1, 16'(c0)});
    out_q1.push_back({16'd2, 16'(c1)});
    out_q1.push_back({16'd3, 16'(c2)});
    out_q1.push_back({16'd4, 16'(c3)});
  endtask

  task automatic test_reset();
    do_reset();
    idx_q1.push_back(0); idx_q1.push_back(1);
    out_q1.push_back({16'd1, 16'd1});
    work1 = 1'b1;
    wait_starts1(2, 100);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (if1.rom_addr !== '0 || if1.aes_start !== 1'b0 || if1.aes_key !== '0 || if1.aes_din !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0d start=%b key=%h din=%h, required all 0", if1.rom_addr, if1.aes_start, if1.aes_key, if1.aes_din);
    end
    checks++;
    if (total1 !== '0 || correct1 !== '0 || run_done1 !== 1'b0 || tmo1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: total=%0d correct=%0d run_done=%b tmo=%b, required all 0", total1, correct1, run_done1, tmo1);
    end
    work1 = 1'b0;
    clear_sb();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idx_q1.push_back(0);
    out_q1.push_back({16'd1, 16'd1});
    work1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if1.aes_start !== (i == 3)) begin
        errors++;
        $display("FAIL reset_latency: aes_start=%b at cycle %0d after work, required %b", if1.aes_start, i, (i == 3));
      end
      if (i < 3) @(negedge clk);
    end
    work1 = 1'b0;
    wait_total1(1, 100);
    repeat (4) @(negedge clk);
    checks++;
    if (starts1 !== 1 || if1.rom_addr !== 2'd1) begin
      errors++;
      $display("FAIL reset_resume: starts=%0d addr=%0d, required starts=1 addr=1", starts1, if1.rom_addr);
    end
  endtask

  task automatic test_full_run();
    do_reset();
    push_run1(1, 2, 3, 4);
    work1 = 1'b1;
    wait_run_done1(300);
    checks++;
    if (starts1 !== 4) begin
      errors++;
      $display("FAIL run_starts: starts=%0d, required 4", starts1);
    end
    for (int i = 0; i + 1 < sc1.size(); i++) begin
      checks++;
      if (sc1[i+1] - sc1[i] != L1 + 5) begin
        errors++;
        $display("FAIL run_period: start spacing=%0d, required %0d", sc1[i+1] - sc1[i], L1 + 5);
      end
    end
    checks++;
    if (total1 !== 16'd4 || correct1 !== 16'd4 || if1.rom_addr !== '0) begin
      errors++;
      $display("FAIL run_final: total=%0d correct=%0d addr=%0d, required 4 4 0", total1, correct1, if1.rom_addr);
    end
    work1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (run_done1 !== 1'b0 || if1.rom_addr !== '0 || starts1 !== 4) begin
      errors++;
      $display("FAIL run_stop: run_done=%b addr=%0d starts=%0d, required 0 0 4", run_done1, if1.rom_addr, starts1);
    end
    checks++;
    if (out_q1.size() != 0 || idx_q1.size() != 0) begin
      errors++;
      $display("FAIL run_drain: pending outcomes=%0d vectors=%0d, required 0 0", out_q1.size(), idx_q1.size());
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    rc[2][0] = ~rc[2][0];
    push_run1(1, 2, 2, 3);
    work1 = 1'b1;
    wait_run_done1(300);
    checks++;
    if (total1 !== 16'd4 || correct1 !== 16'd3 || tmo1 !== 1'b0) begin
      errors++;
      $display("FAIL mismatch: total=%0d correct=%0d tmo=%b, required 4 3 0", total1, correct1, tmo1);
    end
    work1 = 1'b0;
    rc[2][0] = ~rc[2][0];
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    sup1 = 1; late_en = 1'b1;
    push_run1(1, 1, 2, 3);
    work1 = 1'b1;
    wait_run_done1(500);
    checks++;
    if (sc1.size() < 3 || sc1[1] - sc1[0] != 16 || sc1[2] - sc1[1] != 69) begin
      errors++;
      $display("FAIL timeout_period: %0d starts, spacing %0d/%0d, required 16/69",
               sc1.size(), (sc1.size() > 1) ? sc1[1] - sc1[0] : -1, (sc1.size() > 2) ? sc1[2] - sc1[1] : -1);
    end
    checks++;
    if (total1 !== 16'd4 || correct1 !== 16'd3 || tmo1 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_final: total=%0d correct=%0d tmo=%b, required 4 3 1", total1, correct1, tmo1);
    end
    work1 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tmo1 !== 1'b1 || run_done1 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: tmo=%b run_done=%b, required 1 0", tmo1, run_done1);
    end
  endtask

  task automatic test_stop_resume();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idx_q1.push_back(i);
      out_q1.push_back({16'(i + 1), 16'(i + 1)});
    end
    work1 = 1'b1;
    wait_starts1(3, 200);
    repeat (3) @(negedge clk);
    work1 = 1'b0;
    wait_total1(3, 100);
    repeat (20) @(negedge clk);
    checks++;
    if (total1 !== 16'd3 || if1.rom_addr !== 2'd3 || starts1 !== 3 || run_done1 !== 1'b0) begin
      errors++;
      $display("FAIL stop: total=%0d addr=%0d starts=%0d run_done=%b, required 3 3 3 0", total1, if1.rom_addr, starts1, run_done1);
    end
    idx_q1.push_back(3);
    out_q1.push_back({16'd4, 16'd4});
    work1 = 1'b1;
    wait_starts1(4, 50);
    checks++;
    if (if1.aes_key !== rk[3]) begin
      errors++;
      $display("FAIL resume_key: key=%h, required %h", if1.aes_key, rk[3]);
    end
    wait_run_done1(100);
    checks++;
    if (total1 !== 16'd4 || correct1 !== 16'd4) begin
      errors++;
      $display("FAIL resume_final: total=%0d correct=%0d, required 4 4", total1, correct1);
    end
    work1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loop_saturate();
    do_reset();
    for (int i = 0; i < 10; i++) idx_q2.push_back(i % NV);
    for (int i = 1; i <= 7; i++) out_q2.push_back({3'(i), 3'(i)});
    work2 = 1'b1;
    wait_starts2(10, 300);
    repeat (2) @(negedge clk);
    work2 = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (starts2 !== 10 || total2 !== 3'd7 || correct2 !== 3'd7) begin
      errors++;
      $display("FAIL loop_sat: starts=%0d total=%0d correct=%0d, required 10 7 7", starts2, total2, correct2);
    end
    checks++;
    if (if2.rom_addr !== 2'd2 || run_done2 !== 1'b0 || tmo2 !== 1'b0) begin
      errors++;
      $display("FAIL loop_state: addr=%0d run_done=%b tmo=%b, required 2 0 0", if2.rom_addr, run_done2, tmo2);
    end
    checks++;
    if (idx_q2.size() != 0 || out_q2.size() != 0) begin
      errors++;
      $display("FAIL loop_drain: pending vectors=%0d outcomes=%0d, required 0 0", idx_q2.size(), out_q2.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NV; i++) begin
      rk[i] = {$urandom, $urandom, $urandom, $urandom};
      rp[i] = {$urandom, $urandom, $urandom, $urandom};
      rc[i] = core_f(rk[i], rp[i]);
    end
    test_reset();
    test_full_run();
    test_mismatch();
    test_timeout();
    test_stop_resume();
    test_loop_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
